keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the calculator datapath: drives a 4x4 keypad column by column, synchronizes and debounces the row returns, and decodes the key. It sits directly upstream of the input-control FSM. It delivers a clean, debounced `key_pressed` level together with `is_sign_key` and a digit value, so the FSM's own edge detector sees exactly one rising edge per physical press.

## Interface
- `SCAN_DIV`, default 2700: clock cycles each column is driven before moving to the next column (minimum 2).
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required to accept a press or a release (minimum 2).
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  synchronous, active-high reset.
- `row_n`  in  4  keypad rows; active-low, pulled up externally, asynchronous to `clk`.
- `col_n`  out  4  column drive; active-low, one-hot low.
- `key_pressed`  out  1  level; high from debounced press until debounced release.
- `key_valid`  out  1  one-cycle pulse on press acceptance.
- `key_code`  out  4  raw position, equal to {row, col}.
- `key_digit`  out  4  decimal value 0–9 for digit keys; 0 for non-digit keys.
- `is_sign_key`  out  3  key class (encoding under Operation).

## Operation
- **Layout** (row0 to row3, col0 to col3):
  - Row 0: `1 2 3 A`
  - Row 1: `4 5 6 B`
  - Row 2: `7 8 9 C`
  - Row 3: `* 0 # D`
- **Class encoding:**
  - Digit keys: `is_sign_key`=000.
  - `A` (multiply): 001.
  - `#` (equals): 100.
  - `B`, `C`, `D`, `*`: 111.
- **Input synchronizer:** `row_n` passes through a 2-FF synchronizer to give `row_s`. `row_s` resets to 4'b1111. All logic uses `row_s`.
- **Reset values:**
  - `col_n`=4'b1110 (col0 driven).
  - `key_pressed`=0, `key_valid`=0, `key_code`=0, `key_digit`=0, `is_sign_key`=000.
  - State SCAN, all counters 0.
- **SCAN:**
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - At `scan_cnt`==SCAN_DIV-1 with `row_s`==4'b1111: advance the column (0→1→2→3→0, wrapping) and clear `scan_cnt`.
  - At `scan_cnt`==SCAN_DIV-1 with any row low: latch the current column and the lowest-numbered low row, freeze the column drive, clear `db_cnt`, go to DEBOUNCE.
- **DEBOUNCE:**
  - Latched row low: `db_cnt`++.
  - Latched row high (bounce): clear counters, advance the column, return to SCAN. No outputs change.
  - At `db_cnt`==DEBOUNCE_CYCLES-1 with the row still low: go to PRESSED. On that edge:
    - `key_pressed`←1 and `key_valid`←1 for one cycle.
    - `key_code`, `key_digit` and `is_sign_key` load together from the decode.
- **PRESSED:**
  - Hold all outputs; `key_valid` is 0.
  - When the latched row reads high: clear `db_cnt` and go to RELEASE.
- **RELEASE:**
  - Latched row high: `db_cnt`++.
  - Latched row low: `db_cnt`←0 and stay in RELEASE.
  - At `db_cnt`==DEBOUNCE_CYCLES-1 with the row high: `key_pressed`←0, advance the column, return to SCAN.
- **Holding outputs:** `key_code`, `key_digit` and `is_sign_key` keep their last value after release and change only on the next `key_valid`.
- **Multiple keys:** while in DEBOUNCE, PRESSED or RELEASE, other keys are ignored; only the latched row/column is observed. No rollover and no queueing.
- **Reset mid-operation:** all outputs return to their reset values on the next edge, from any state. A key still held after reset is detected afresh and produces a new press.

## Timing
- Synchronizer latency: 2 cycles from a `row_n` change to `row_s`.
- Each column is driven for exactly SCAN_DIV cycles, so one full sweep takes 4·SCAN_DIV cycles.
- Press latency: DEBOUNCE entry at edge E; `key_valid` and `key_pressed` go high at edge E+DEBOUNCE_CYCLES.
- Release latency: RELEASE entry at edge R; `key_pressed` falls at edge R+DEBOUNCE_CYCLES.
- `is_sign_key` and `key_digit` are valid in the same cycle `key_pressed` rises and remain stable while it is high, so the downstream FSM may sample them on its detected rising edge.
- `key_valid` is never high in two consecutive cycles. Successive presses are separated by at least 2·DEBOUNCE_CYCLES cycles.
- `col_n` is always exactly one bit low, including during reset.

## Test plan
Run all scenarios with SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
- **Reset:** hold `rst` 3 cycles → `col_n`=1110, all outputs 0. With no keys held, `col_n` cycles 1110→1101→1011→0111→1110, 4 cycles per column.
- **Clean press of `5`:** hold row1/col1 low for 40 cycles → exactly one `key_valid` pulse, `key_code`=4'h5, `key_digit`=5, `is_sign_key`=000. `key_pressed` stays high until 8 cycles after the row returns high.
- **Bouncy press of `A`:** row0 toggles with a 3-cycle period while col3 is driven, then holds low → no `key_valid` during the bounce. One pulse follows 8 stable cycles, with `is_sign_key`=001 and `key_digit`=0.
- **Release bounce on `#`:** after acceptance, toggle row3 high/low 4 times and then release → `key_pressed` stays high throughout and falls exactly 8 cycles after the last high transition, with `is_sign_key`=100.
- **Simultaneous keys:** hold `0` (row3/col1) and `1` (row0/col0) together, so `1` is reached first in the scan → only `1` is reported. Releasing `1` while `0` stays held yields a second press reporting `0`.
- **Reset mid-press:** assert `rst` while in PRESSED for `9` → outputs clear on the next edge. With `9` still held, a new `key_valid` appears after the scan reaches col2 plus 8 cycles.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix-keypad front end.
// Drives columns one at a time, synchronizes and debounces the row returns,
// and decodes the latched key into a position code, a digit value and a class.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   row_n[3:0]   keypad rows, active-low, asynchronous to clk
//   col_n[3:0]   column drive, active-low, exactly one bit low
//   key_pressed  debounced press level
//   key_valid    one-cycle pulse when a press is accepted
//   key_code     {row, col} of the accepted key
//   key_digit    decimal value of digit keys, 0 otherwise
//   is_sign_key  key class: 000 digit, 001 A, 100 #, 111 B/C/D/*
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 2700,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_pressed,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] key_digit,
  output logic [2:0] is_sign_key
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_d;
  logic [3:0]    row_meta, row_s;
  logic [SW-1:0] scan_cnt, scan_cnt_d;
  logic [DW-1:0] db_cnt, db_cnt_d;
  logic [1:0]    col, col_d;
  logic [1:0]    lat_row, lat_row_d;
  logic [1:0]    low_row;
  logic          row_low;
  logic          key_pressed_d, key_valid_d;
  logic [3:0]    key_code_d, key_digit_d;
  logic [2:0]    is_sign_key_d;
  logic [3:0]    dec_digit;
  logic [2:0]    dec_class;

  assign col_n   = ~(4'b0001 << col);
  assign row_low = ~row_s[lat_row];

  // Lowest-numbered low row wins when several rows are low at once.
  always_comb begin
    if (!row_s[0])      low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
    else                low_row = 2'd3;
  end

  // Decode of the latched position.
  always_comb begin
    dec_digit = '0;
    dec_class = 3'b000;
    case ({lat_row, col})
      4'h3:                      dec_class = 3'b001;
      4'hE:                      dec_class = 3'b100;
      4'h7, 4'hB, 4'hC, 4'hF:    dec_class = 3'b111;
      4'hD:                      dec_digit = 4'd0;
      default: dec_digit = ({2'b00, lat_row} * 4'd3) + {2'b00, col} + 4'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta    <= '1;
      row_s       <= '1;
      state       <= SCAN;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      col         <= '0;
      lat_row     <= '0;
      key_pressed <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_digit   <= '0;
      is_sign_key <= '0;
    end else begin
      row_meta    <= row_n;
      row_s       <= row_meta;
      state       <= state_d;
      scan_cnt    <= scan_cnt_d;
      db_cnt      <= db_cnt_d;
      col         <= col_d;
      lat_row     <= lat_row_d;
      key_pressed <= key_pressed_d;
      key_valid   <= key_valid_d;
      key_code    <= key_code_d;
      key_digit   <= key_digit_d;
      is_sign_key <= is_sign_key_d;
    end
  end

  always_comb begin
    state_d       = state;
    scan_cnt_d    = scan_cnt;
    db_cnt_d      = db_cnt;
    col_d         = col;
    lat_row_d     = lat_row;
    key_pressed_d = key_pressed;
    key_valid_d   = 1'b0;
    key_code_d    = key_code;
    key_digit_d   = key_digit;
    is_sign_key_d = is_sign_key;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (row_s == 4'b1111) begin
            col_d = col + 2'd1;
          end else begin
            lat_row_d = low_row;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_low) begin
          if (db_cnt == DB_LAST) begin
            state_d       = PRESSED;
            key_pressed_d = 1'b1;
            key_valid_d   = 1'b1;
            key_code_d    = {lat_row, col};
            key_digit_d   = dec_digit;
            is_sign_key_d = dec_class;
          end else begin
            db_cnt_d = db_cnt + 1'b1;
          end
        end else begin
          db_cnt_d   = '0;
          scan_cnt_d = '0;
          col_d      = col + 2'd1;
          state_d    = SCAN;
        end
      end
      PRESSED: begin
        if (!row_low) begin
          db_cnt_d = '0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!row_low) begin
          if (db_cnt == DB_LAST) begin
            key_pressed_d = 1'b0;
            db_cnt_d      = '0;
            scan_cnt_d    = '0;
            col_d         = col + 2'd1;
            state_d       = SCAN;
          end else begin
            db_cnt_d = db_cnt + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A combinational keypad model pulls a row low when a held key sits on the
// currently driven column. Inputs change and outputs are sampled on negedges.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_pressed;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  key_digit;
  logic [2:0]  is_sign_key;
  logic [15:0] held;   // index row*4+col

  int n_tests = 0;
  int n_fail  = 0;
  int vcount  = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_pressed(key_pressed), .key_valid(key_valid), .key_code(key_code),
    .key_digit(key_digit), .is_sign_key(is_sign_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) vcount++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin step(); n++; end while (key_valid !== 1'b1 && n < 200);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    do begin step(); n++; end while (key_pressed !== 1'b0 && n < 200);
  endtask

  task automatic check_key(input string tag, input int code, input int digit, input int cls);
    check({tag, "_pressed"}, int'(key_pressed), 1);
    check({tag, "_code"},    int'(key_code), code);
    check({tag, "_digit"},   int'(key_digit), digit);
    check({tag, "_class"},   int'(is_sign_key), cls);
  endtask

  initial begin
    int n;
    int v0;
    logic [3:0] exp_col;
    held = '0;
    rst  = 1'b1;
    repeat (3) step();

    check("rst_col_n", int'(col_n), 4'b1110);
    check("rst_pressed", int'(key_pressed), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_digit", int'(key_digit), 0);
    check("rst_class", int'(is_sign_key), 0);
    rst = 1'b0;

    // Idle sweep: 4 cycles per column, wrapping.
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("sweep_col_n", int'(col_n), int'(exp_col));
    end

    // Clean press of 5 (row1/col1), held 40 cycles.
    v0 = vcount;
    held[5] = 1'b1;
    wait_valid(n);
    check("p5_latency", n, 16);
    check_key("p5", 5, 5, 0);
    check("p5_col_frozen", int'(col_n), 4'b1101);
    step();
    check("p5_valid_one_cycle", int'(key_valid), 0);
    repeat (23) step();
    check("p5_pulses", vcount - v0, 1);
    held[5] = 1'b0;
    wait_release(n);
    check("p5_release_latency", n, 11);
    check("p5_code_held", int'(key_code), 5);
    check("p5_digit_held", int'(key_digit), 5);

    // Bouncy press of A (row0/col3): 3-cycle toggling, then solid.
    v0 = vcount;
    n = 0;
    do begin
      held[3] = (n < 12) ? (n % 3 != 0) : 1'b1;
      step();
      n++;
    end while (key_valid !== 1'b1 && n < 200);
    check("pA_latency", n, 33);
    check("pA_pulses", vcount - v0, 1);
    check_key("pA", 3, 0, 1);
    held[3] = 1'b0;
    wait_release(n);
    check("pA_release_latency", n, 11);

    // Press of #, then release bounce.
    held[14] = 1'b1;
    wait_valid(n);
    check("pH_latency", n, 20);
    check_key("pH", 14, 0, 4);
    n = 0;
    do begin
      held[14] = (n < 8) ? (n % 2 == 1) : 1'b0;
      step();
      n++;
    end while (key_pressed !== 1'b0 && n < 200);
    check("pH_release_bounce_latency", n, 18);
    check("pH_class_held", int'(is_sign_key), 4);

    // Simultaneous 0 (row3/col1) and 1 (row0/col0).
    v0 = vcount;
    held[13] = 1'b1;
    held[0]  = 1'b1;
    wait_valid(n);
    check("p1_latency", n, 16);
    check_key("p1", 0, 1, 0);
    held[0] = 1'b0;
    wait_release(n);
    check("p1_release_latency", n, 11);
    check("p1_single_pulse", vcount - v0, 1);
    wait_valid(n);
    check("p0_latency", n, 12);
    check_key("p0", 13, 0, 0);
    held[13] = 1'b0;
    wait_release(n);
    check("p0_release_latency", n, 11);

    // Reset while 9 (row2/col2) is in PRESSED.
    held[10] = 1'b1;
    wait_valid(n);
    check("p9_latency", n, 12);
    check_key("p9", 10, 9, 0);
    repeat (2) step();
    check("p9_still_pressed", int'(key_pressed), 1);
    rst = 1'b1;
    step();
    check("mid_rst_col_n", int'(col_n), 4'b1110);
    check("mid_rst_pressed", int'(key_pressed), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_digit", int'(key_digit), 0);
    check("mid_rst_class", int'(is_sign_key), 0);
    rst = 1'b0;
    wait_valid(n);
    check("p9_redetect_latency", n, 20);
    check_key("p9b", 10, 9, 0);
    held[10] = 1'b0;
    wait_release(n);
    check("p9b_release_latency", n, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
